// File: rtl/fp_pkg.sv
`default_nettype none
//==============================================================================
// Module      : fp (package)
// Description : Single-precision float layout, adder state encoding and helpers
// Revision    : 1.0 - initial release
//==============================================================================
package fp;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = 24;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int               BIAS    = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } add_state_t;

    // Zero exponent means zero: denormals are flushed.
    function automatic logic [MAN_W-1:0] mantissa(input float f);
        return (f.exp == '0) ? '0 : {1'b1, f.frac};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_align_shifter.sv
`default_nettype none
//==============================================================================
// Module      : fp_align_shifter
// Description : 24-bit logarithmic right shifter, zero for amounts of 24 or more
// Revision    : 1.0 - initial release
//==============================================================================
module fp_align_shifter
    import fp::*;
(
    input  logic [MAN_W-1:0] i_man,
    input  logic [EXP_W-1:0] i_amt,
    output logic [MAN_W-1:0] o_man
);

    localparam logic [EXP_W-1:0] c_limit = EXP_W'(MAN_W);

    logic [MAN_W-1:0] w_stage [0:5];

    assign w_stage[0] = i_man;

    generate
        for (genvar i = 0; i < 5; i++) begin : g_stage
            assign w_stage[i+1] = i_amt[i] ? (w_stage[i] >> (1 << i)) : w_stage[i];
        end
    endgenerate

    assign o_man = (i_amt >= c_limit) ? '0 : w_stage[5];

endmodule
`default_nettype wire

// File: rtl/fp_add_core.sv
`default_nettype none
//==============================================================================
// Module      : fp_add_core
// Description : Sequential add/subtract of magnitude-ordered floats with
//               iterative one-bit-per-cycle normalisation
// Revision    : 1.0 - initial release
//==============================================================================
module fp_add_core
    import fp::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  float bign,
    input  float smalln,
    output logic out_valid,
    input  logic out_ready,
    output float sum,
    output logic ovf
);

    add_state_t r_state;
    add_state_t w_next_state;
    logic       w_accept;

    float             r_big;
    float             r_small;
    logic [EXP_W-1:0] r_exp;
    logic [MAN_W-1:0] r_man_big;
    logic [MAN_W-1:0] r_man_small;
    logic [MAN_W:0]   r_acc;
    logic             r_sub;
    float             r_sum;
    logic             r_ovf;
    logic             r_out_valid;

    logic [MAN_W-1:0] w_man_small;
    logic [MAN_W-1:0] w_shifted;
    logic [EXP_W-1:0] w_diff;
    logic [EXP_W-1:0] w_exp_inc;
    logic             w_special;
    logic             w_carry;
    logic             w_zero;
    logic             w_lead;
    logic             w_floor;

    assign w_man_small = mantissa(r_small);
    assign w_diff      = r_big.exp - r_small.exp;

    fp_align_shifter u_align (
        .i_man (w_man_small),
        .i_amt (w_diff),
        .o_man (w_shifted)
    );

    assign w_exp_inc = r_exp + 8'd1;
    assign w_special = (r_big.exp == EXP_MAX);
    assign w_carry   = r_acc[MAN_W];
    assign w_zero    = (r_acc == '0);
    assign w_lead    = r_acc[MAN_W-1];
    // A further left shift would drive the exponent to zero: flush instead.
    assign w_floor   = (r_exp <= 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ALIGN;
                end
            end
            ALIGN: w_next_state = ADD;
            ADD:   w_next_state = NORM;
            NORM: begin
                if (w_special || w_carry || w_zero || w_lead || w_floor) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_big       <= '0;
            r_small     <= '0;
            r_exp       <= '0;
            r_man_big   <= '0;
            r_man_small <= '0;
            r_acc       <= '0;
            r_sub       <= 1'b0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_big   <= bign;
                        r_small <= smalln;
                    end
                end
                ALIGN: begin
                    r_exp       <= r_big.exp;
                    r_man_big   <= mantissa(r_big);
                    r_man_small <= w_shifted;
                    r_sub       <= r_big.sign ^ r_small.sign;
                end
                ADD: begin
                    if (r_sub) begin
                        r_acc <= {1'b0, r_man_big} - {1'b0, r_man_small};
                    end else begin
                        r_acc <= {1'b0, r_man_big} + {1'b0, r_man_small};
                    end
                end
                NORM: begin
                    if (w_special) begin
                        r_sum       <= r_big;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else if (w_carry) begin
                        if (w_exp_inc == EXP_MAX) begin
                            r_sum <= {r_big.sign, EXP_MAX, {FRAC_W{1'b0}}};
                            r_ovf <= 1'b1;
                        end else begin
                            r_sum <= {r_big.sign, w_exp_inc, r_acc[MAN_W-1:1]};
                            r_ovf <= 1'b0;
                        end
                        r_out_valid <= 1'b1;
                    end else if (w_zero) begin
                        r_sum       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else if (w_lead) begin
                        r_sum       <= {r_big.sign, r_exp, r_acc[FRAC_W-1:0]};
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else if (w_floor) begin
                        r_sum       <= {r_big.sign, {(EXP_W+FRAC_W){1'b0}}};
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_acc <= {r_acc[MAN_W-1:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_core.sv
`default_nettype none
//==============================================================================
// Module      : tb_fp_add_core
// Description : Self-checking bench for fp_add_core against an arithmetic model
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fp_add_core;
    import fp::*;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic in_ready;
    float bign;
    float smalln;
    logic out_valid;
    logic out_ready;
    float sum;
    logic ovf;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    bit   head_lat_seen = 1'b0;

    fp_add_core dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bign      (bign),
        .smalln    (smalln),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact integer alignment, then place the leading one; lat = -1 means don't care.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        int     ea, eb, d, msb, e, sh;
        longint ma, mb, sm, v;
        r.ovf     = 1'b0;
        r.lat     = 3;
        r.acc_cyc = 0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255) begin
            r.sum = a;
            return r;
        end
        ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
        mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
        d  = ea - eb;
        sm = (eb == 0 || d >= 24) ? 0 : (mb >> d);
        v  = (a[31] != b[31]) ? ma - sm : ma + sm;
        if (v == 0) begin
            r.sum = 32'h0;
            return r;
        end
        msb = 0;
        for (int i = 0; i < 26; i++) if (v[i]) msb = i;
        e = ea + msb - 23;
        if (msb == 24) begin
            if (e >= 255) begin
                r.sum = {a[31], 8'hFF, 23'd0};
                r.ovf = 1'b1;
            end else begin
                r.sum = {a[31], 8'(e), 23'(v >> 1)};
            end
            return r;
        end
        sh = 23 - msb;
        if (e < 1) begin
            r.sum = {a[31], 31'd0};
            r.lat = -1;
        end else begin
            r.sum = {a[31], 8'(e), 23'(v << sh)};
            r.lat = 3 + sh;
        end
        return r;
    endfunction

    // Single compare process: checks every cycle against the expected-result queue.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_sum", sum, 32'h0);
            chk("rst_ovf", 32'(ovf), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            q.delete();
            head_lat_seen = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            if (q.size() == 0) begin
                chk("idle_out_valid", 32'(out_valid), 32'h0);
            end else if (out_valid) begin
                chk("sum", sum, q[0].sum);
                chk("ovf", 32'(ovf), 32'(q[0].ovf));
                if (!head_lat_seen) begin
                    head_lat_seen = 1'b1;
                    if (q[0].lat >= 0) chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    head_lat_seen = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                exp_t m;
                m         = model(bign, smalln);
                m.acc_cyc = cyc + 1;
                q.push_back(m);
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        bit ok;
        @(posedge clk); #1;
        bign      = a;
        smalln    = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        chk("accept_in_time", 32'(ok), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        bign     = $urandom;
        smalln   = $urandom;
        if (!ok) return;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        chk("result_in_time", 32'(ok), 32'h1);
        if (!ok) begin
            out_ready = 1'b1;
            return;
        end
        repeat (hold) @(posedge clk);
        if (hold > 0) begin
            #1 out_ready = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic gen(output logic [31:0] a, output logic [31:0] b);
        logic [7:0]  e1, e2;
        logic [22:0] f1, f2;
        logic [31:0] x, y;
        int          t;
        f1 = 23'($urandom);
        f2 = 23'($urandom);
        e1 = 8'($urandom_range(1, 254));
        t  = int'(e1) - int'($urandom_range(0, 30));
        case ($urandom_range(0, 5))
            0: begin
                t  = int'(e1) - int'($urandom_range(0, 2));
                f2 = f1 ^ 23'($urandom_range(0, 255));
            end
            1: ;
            2: t = int'($urandom_range(0, 254));
            3: begin
                e1 = 8'($urandom_range(252, 254));
                t  = int'(e1) - int'($urandom_range(0, 1));
            end
            4: begin
                e1 = 8'($urandom_range(1, 4));
                t  = int'(e1);
                f2 = f1 ^ 23'($urandom_range(0, 3));
            end
            default: if ($urandom_range(0, 1) == 1) e1 = 8'hFF; else t = 0;
        endcase
        e2 = (t < 0) ? 8'd0 : 8'(t);
        x  = {1'($urandom), e1, f1};
        y  = {1'($urandom), e2, f2};
        if (y[30:0] > x[30:0]) begin a = y; b = x; end
        else begin a = x; b = y; end
    endtask

    logic [31:0] ta   [8];
    logic [31:0] tb_b [8];
    logic [31:0] tsum [8];
    logic        tovf [8];
    int          tlat [8];

    initial begin
        exp_t        m;
        logic [31:0] ra, rb;
        ta   = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h40400000,
                 32'h7F7FFFFF, 32'h4B800000, 32'h7FC00000, 32'h80800001};
        tb_b = '{32'h3F800000, 32'h3E800000, 32'hBF400000, 32'hC0400000,
                 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h00800000};
        tsum = '{32'h40000000, 32'h3FE00000, 32'h3E800000, 32'h00000000,
                 32'h7F800000, 32'h4B800000, 32'h7FC00000, 32'h80000000};
        tovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tlat = '{3, 3, 5, 3, 3, 3, 3, -1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bign      = '0;
        smalln    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            m = model(ta[i], tb_b[i]);
            chk("pin_sum", m.sum, tsum[i]);
            chk("pin_ovf", 32'(m.ovf), 32'(tovf[i]));
            chk("pin_lat", 32'(m.lat), 32'(tlat[i]));
            do_op(ta[i], tb_b[i], (i == 1) ? 5 : 0);
        end

        // Reset while the 1.0 - 0.75 case is normalising.
        @(posedge clk); #1;
        bign      = 32'h3F800000;
        smalln    = 32'hBF400000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        do_op(32'h3F800000, 32'h3F800000, 0);

        for (int n = 0; n < 300; n++) begin
            gen(ra, rb);
            do_op(ra, rb, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fails);
        $fatal(1);
    end

endmodule
`default_nettype wire
